// File: rtl/bp_piton_l15_fill_assembler.sv
// L1.5 return-beat to BlackParrot cache-line fill assembler (I$ 4 beats, D$ 2 beats).
// Define BP_PITON_FILL_CWF_EN to place beats critical-word-first.
module bp_piton_l15_fill_assembler #(
  parameter int beat_width_p        = 64,
  parameter int icache_fill_width_p = 256,
  parameter int dcache_fill_width_p = 128,
  parameter int tag_width_p         = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           hdr_v_i,
  output logic                           hdr_ready_and_o,
  input  logic                           hdr_icache_i,
  input  logic [1:0]                     hdr_word_i,
  input  logic [tag_width_p-1:0]         hdr_tag_i,
  input  logic                           beat_v_i,
  output logic                           beat_ready_and_o,
  input  logic [beat_width_p-1:0]        beat_data_i,
  output logic                           fill_v_o,
  input  logic                           fill_yumi_i,
  output logic                           fill_icache_o,
  output logic [tag_width_p-1:0]         fill_tag_o,
  output logic [icache_fill_width_p-1:0] fill_data_o,
  output logic                           err_o
);

  localparam logic [1:0] ic_last_lp =
    2'(icache_fill_width_p / beat_width_p - 1);
  localparam logic [1:0] dc_last_lp =
    2'(dcache_fill_width_p / beat_width_p - 1);

  typedef enum logic [1:0] {
    e_idle,
    e_collect,
    e_out
  } state_e;

  state_e state_q, state_d;

  logic [1:0]                     cnt_q, cnt_d;
  logic                           icache_q, icache_d;
  logic [tag_width_p-1:0]         tag_q, tag_d;
  logic [icache_fill_width_p-1:0] line_q, line_d;
  logic                           err_q, err_d;

  logic       hdr_hs;
  logic       beat_hs;
  logic       last_beat;
  logic [1:0] slot;

  assign hdr_ready_and_o  = (state_q == e_idle)
                          | ((state_q == e_out) & fill_yumi_i);
  assign beat_ready_and_o = (state_q == e_collect);
  assign hdr_hs  = hdr_v_i & hdr_ready_and_o;
  assign beat_hs = beat_v_i & beat_ready_and_o;
  assign last_beat = (cnt_q == (icache_q ? ic_last_lp : dc_last_lp));

`ifdef BP_PITON_FILL_CWF_EN
  logic [1:0] word_q, word_d;
  logic [1:0] rot;

  // D$ keeps only bit 0 of the word, so a 1-bit rotate wraps at 2
  assign rot  = word_q + cnt_q;
  assign slot = icache_q ? rot : {1'b0, rot[0]};

  always_comb begin
    word_d = word_q;
    if (hdr_hs)
      word_d = hdr_icache_i ? hdr_word_i : {1'b0, hdr_word_i[0]};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) word_q <= '0;
    else         word_q <= word_d;
  end
`else
  logic unused_word;

  assign unused_word = hdr_word_i[0];
  assign slot        = cnt_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    icache_d = icache_q;
    tag_d    = tag_q;
    line_d   = line_q;
    err_d    = 1'b0;

    unique case (state_q)
      e_idle:
        if (hdr_hs) state_d = e_collect;
      e_collect:
        if (beat_hs & last_beat) state_d = e_out;
      e_out:
        if (fill_yumi_i) state_d = hdr_hs ? e_collect : e_idle;
      default:
        state_d = e_idle;
    endcase

    if (hdr_hs) begin
      cnt_d    = '0;
      icache_d = hdr_icache_i;
      tag_d    = hdr_tag_i;
      line_d   = '0;
      err_d    = ~hdr_icache_i & hdr_word_i[1];
    end

    if (beat_hs) begin
      cnt_d = cnt_q + 2'd1;
      line_d[int'(slot)*beat_width_p +: beat_width_p] = beat_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      cnt_q    <= '0;
      icache_q <= 1'b0;
      tag_q    <= '0;
      line_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      icache_q <= icache_d;
      tag_q    <= tag_d;
      line_q   <= line_d;
      err_q    <= err_d;
    end
  end

  assign fill_v_o      = (state_q == e_out);
  assign fill_icache_o = icache_q;
  assign fill_tag_o    = tag_q;
  assign fill_data_o   = line_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_bp_piton_l15_fill_assembler.sv
// Randomized bench for bp_piton_l15_fill_assembler against a line-level model.
// Inputs are driven on the falling edge; outputs are sampled there too.
module tb_bp_piton_l15_fill_assembler;

  typedef logic [63:0] beats_t [4];

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         hdr_v_i = 1'b0;
  logic         hdr_ready_and_o;
  logic         hdr_icache_i = 1'b0;
  logic [1:0]   hdr_word_i = '0;
  logic [3:0]   hdr_tag_i = '0;
  logic         beat_v_i = 1'b0;
  logic         beat_ready_and_o;
  logic [63:0]  beat_data_i = '0;
  logic         fill_v_o;
  logic         fill_yumi_i = 1'b0;
  logic         fill_icache_o;
  logic [3:0]   fill_tag_o;
  logic [255:0] fill_data_o;
  logic         err_o;

  int errs = 0;
  int checks = 0;

  bit           cur_ic;
  logic [3:0]   cur_tag;
  logic [255:0] cur_line;
  int           cur_n;
  bit           in_out;

  always #5 clk = ~clk;

  bp_piton_l15_fill_assembler dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .hdr_v_i          (hdr_v_i),
    .hdr_ready_and_o  (hdr_ready_and_o),
    .hdr_icache_i     (hdr_icache_i),
    .hdr_word_i       (hdr_word_i),
    .hdr_tag_i        (hdr_tag_i),
    .beat_v_i         (beat_v_i),
    .beat_ready_and_o (beat_ready_and_o),
    .beat_data_i      (beat_data_i),
    .fill_v_o         (fill_v_o),
    .fill_yumi_i      (fill_yumi_i),
    .fill_icache_o    (fill_icache_o),
    .fill_tag_o       (fill_tag_o),
    .fill_data_o      (fill_data_o),
    .err_o            (err_o)
  );

  task automatic chk(string t, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask

  function automatic logic [255:0] model(bit ic, logic [1:0] w, beats_t b);
    logic [255:0] l;
    int n;
    int s;
    l = '0;
    n = ic ? 4 : 2;
    for (int k = 0; k < n; k++) begin
`ifdef BP_PITON_FILL_CWF_EN
      s = (int'(w) + k) % n;
`else
      s = k;
`endif
      l[s*64 +: 64] = b[k];
    end
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_chk(string t);
    chk({t, "_hdr_rdy"}, 256'(hdr_ready_and_o), 256'(1));
    chk({t, "_beat_rdy"}, 256'(beat_ready_and_o), 256'(0));
    chk({t, "_fill_v"}, 256'(fill_v_o), 256'(0));
    chk({t, "_icache"}, 256'(fill_icache_o), 256'(0));
    chk({t, "_tag"}, 256'(fill_tag_o), 256'(0));
    chk({t, "_data"}, fill_data_o, 256'(0));
    chk({t, "_err"}, 256'(err_o), 256'(0));
  endtask

  // Present a header (optionally with yumi of the pending line)
  task automatic hdr_go(bit ic, logic [1:0] w, logic [3:0] tag,
                        beats_t b, bit yumi);
    hdr_v_i      = 1'b1;
    hdr_icache_i = ic;
    hdr_word_i   = w;
    hdr_tag_i    = tag;
    fill_yumi_i  = yumi;
    beat_v_i     = 1'b0;
    #1;
    chk("hdr_rdy", 256'(hdr_ready_and_o), 256'(1));
    step();
    hdr_v_i     = 1'b0;
    fill_yumi_i = 1'b0;
    chk("err_pulse", 256'(err_o), 256'(!ic && w[1]));
    chk("fill_v_after_hdr", 256'(fill_v_o), 256'(0));
    chk("beat_rdy_after_hdr", 256'(beat_ready_and_o), 256'(1));
    cur_ic   = ic;
    cur_tag  = tag;
    cur_n    = ic ? 4 : 2;
    cur_line = model(ic, w, b);
    in_out   = 1'b0;
  endtask

  task automatic beats_go(beats_t b, int max_stall, int nb);
    int stall;
    for (int k = 0; k < nb; k++) begin
      stall = $urandom_range(0, max_stall);
      repeat (stall) begin
        beat_v_i    = 1'b0;
        fill_yumi_i = 1'($urandom);
        #1;
        chk("beat_rdy_stall", 256'(beat_ready_and_o), 256'(1));
        step();
        fill_yumi_i = 1'b0;
      end
      beat_v_i    = 1'b1;
      beat_data_i = b[k];
      #1;
      chk("beat_rdy", 256'(beat_ready_and_o), 256'(1));
      chk("fill_v_early", 256'(fill_v_o), 256'(0));
      step();
      beat_v_i = 1'b0;
    end
    if (nb == cur_n) begin
      chk("fill_v", 256'(fill_v_o), 256'(1));
      chk("fill_icache", 256'(fill_icache_o), 256'(cur_ic));
      chk("fill_tag", 256'(fill_tag_o), 256'(cur_tag));
      chk("fill_data", fill_data_o, cur_line);
      chk("err_once", 256'(err_o), 256'(0));
      in_out = 1'b1;
    end
  endtask

  task automatic hold(int cyc);
    repeat (cyc) begin
      beat_v_i    = 1'b1;
      beat_data_i = {$urandom, $urandom};
      fill_yumi_i = 1'b0;
      #1;
      chk("bp_beat_rdy", 256'(beat_ready_and_o), 256'(0));
      chk("bp_fill_v", 256'(fill_v_o), 256'(1));
      chk("bp_data", fill_data_o, cur_line);
      step();
    end
    beat_v_i = 1'b0;
  endtask

  task automatic release_idle();
    fill_yumi_i = 1'b1;
    #1;
    chk("rel_hdr_rdy", 256'(hdr_ready_and_o), 256'(1));
    step();
    fill_yumi_i = 1'b0;
    chk("rel_fill_v", 256'(fill_v_o), 256'(0));
    chk("rel_idle_rdy", 256'(hdr_ready_and_o), 256'(1));
    in_out = 1'b0;
  endtask

  function automatic beats_t mk(logic [63:0] a, logic [63:0] b2,
                                logic [63:0] c, logic [63:0] d);
    beats_t r;
    r[0] = a;
    r[1] = b2;
    r[2] = c;
    r[3] = d;
    return r;
  endfunction

  initial begin
    beats_t b;
    logic [255:0] exp;
    bit ic;
    logic [1:0] w;
    logic [3:0] tg;

    #2;
    reset_chk("rst");
    @(negedge clk);
    reset_i = 1'b0;
    step();
    reset_chk("post_rst");

    // stray yumi in idle must be ignored
    fill_yumi_i = 1'b1;
    step();
    fill_yumi_i = 1'b0;
    chk("stray_yumi_v", 256'(fill_v_o), 256'(0));
    chk("stray_yumi_rdy", 256'(hdr_ready_and_o), 256'(1));

    b = mk(64'hA, 64'hB, 64'hC, 64'hD);
    hdr_go(1'b1, 2'd0, 4'h5, b, 1'b0);
    beats_go(b, 0, 4);
    chk("ic_w0_const", fill_data_o,
        {64'hD, 64'hC, 64'hB, 64'hA});
    release_idle();

    hdr_go(1'b1, 2'd2, 4'h9, b, 1'b0);
    beats_go(b, 0, 4);
`ifdef BP_PITON_FILL_CWF_EN
    exp = {64'hB, 64'hA, 64'hD, 64'hC};
`else
    exp = {64'hD, 64'hC, 64'hB, 64'hA};
`endif
    chk("ic_w2_const", fill_data_o, exp);
    release_idle();

    b = mk(64'h11, 64'h22, 64'h0, 64'h0);
    hdr_go(1'b0, 2'd3, 4'h3, b, 1'b0);
    beats_go(b, 0, 2);
`ifdef BP_PITON_FILL_CWF_EN
    exp = {128'h0, 64'h11, 64'h22};
`else
    exp = {128'h0, 64'h22, 64'h11};
`endif
    chk("dc_w3_const", fill_data_o, exp);

    hold(5);
    b = mk(64'h1111, 64'h2222, 64'h3333, 64'h4444);
    hdr_go(1'b1, 2'd1, 4'hC, b, 1'b1);
    beats_go(b, 0, 4);
    release_idle();

    b = mk(64'hDEAD0, 64'hDEAD1, 64'hDEAD2, 64'hDEAD3);
    hdr_go(1'b1, 2'd0, 4'hF, b, 1'b0);
    beats_go(b, 0, 2);
    reset_i = 1'b1;
    #1;
    reset_chk("mid_rst");
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    reset_chk("after_rst");
    @(negedge clk);
    b = mk(64'h5555, 64'h6666, 64'h0, 64'h0);
    hdr_go(1'b0, 2'd1, 4'h7, b, 1'b0);
    beats_go(b, 0, 2);
    chk("dc_upper_zero", 256'(fill_data_o[255:128]), 256'(0));
    release_idle();

    for (int i = 0; i < 60; i++) begin
      ic = 1'($urandom);
      w  = 2'($urandom);
      tg = 4'($urandom);
      for (int k = 0; k < 4; k++) b[k] = {$urandom, $urandom};
      if (in_out && $urandom_range(0, 1) == 1) begin
        hdr_go(ic, w, tg, b, 1'b1);
      end else begin
        if (in_out) release_idle();
        hdr_go(ic, w, tg, b, 1'b0);
      end
      beats_go(b, 2, cur_n);
      hold($urandom_range(0, 3));
    end
    if (in_out) release_idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bp_piton_l15_fill_assembler.md
# bp_piton_l15_fill_assembler

Assembles 64-bit return beats from the OpenPiton L1.5 return path into whole cache-line fills for the BlackParrot caches. It handles icache fills (256 b, 4 beats) and dcache fills (128 b, 2 beats). It sits directly downstream of the L1.5 return decoder and upstream of the BP I$/D$ fill engines, sized for the parrotpiton unicore configuration. Placement of each beat within the line can optionally rotate critical-word-first.

## Interface
Parameters:
- `beat_width_p`, 64, width of one L1.5 return beat
- `icache_fill_width_p`, 256, icache fill width; 4 beats
- `dcache_fill_width_p`, 128, dcache fill width; 2 beats
- `tag_width_p`, 4, opaque miss tag carried header-to-fill

Ports:
- `clk_i`  in  1  clock
- `reset_i`  in  1  asynchronous, active-high reset
- `hdr_v_i`  in  1  fill header valid
- `hdr_ready_and_o`  out  1  header accepted when `hdr_v_i & hdr_ready_and_o`
- `hdr_icache_i`  in  1  1 = icache fill (4 beats), 0 = dcache fill (2 beats)
- `hdr_word_i`  in  2  critical beat index
- `hdr_tag_i`  in  `tag_width_p`  miss tag
- `beat_v_i`  in  1  data beat valid
- `beat_ready_and_o`  out  1  beat accepted when `beat_v_i & beat_ready_and_o`
- `beat_data_i`  in  `beat_width_p`  beat payload
- `fill_v_o`  out  1  assembled line valid
- `fill_yumi_i`  in  1  consumer takes line; legal only while `fill_v_o`=1
- `fill_icache_o`  out  1  line type
- `fill_tag_o`  out  `tag_width_p`  tag of the line
- `fill_data_o`  out  `icache_fill_width_p`  line; dcache uses [127:0], [255:128] = 0
- `err_o`  out  1  one-cycle pulse on a malformed header

## Operation
- FSM states and transitions:
  - e_idle → e_collect on header handshake.
  - e_collect → e_out on acceptance of the final beat (beat count N = 4 for icache, 2 for dcache).
  - e_out → e_idle on `fill_yumi_i` with no new header.
  - e_out → e_collect on `fill_yumi_i` together with a header handshake in the same cycle.
- `hdr_ready_and_o` = (state==e_idle) | (state==e_out & `fill_yumi_i`).
- `beat_ready_and_o` = (state==e_collect). Beats arriving in any other state are not accepted and stay pending upstream.
- A 2-bit beat counter `cnt_r` clears on header accept and increments on each beat handshake. The final beat is the one with `cnt_r` == N-1.
- The header registers type, tag and word. For dcache, only `hdr_word_i[0]` is used.
- If a dcache header has `hdr_word_i[1]`=1, `err_o` pulses in the cycle after the header handshake. The header is otherwise processed normally with bit 1 dropped.
- Beat k is written to slot s of the line buffer:
  - with CWF: s = (word + k) mod N
  - without CWF: s = k
- The line buffer is cleared on each header accept, so stale icache upper data never leaks into a dcache fill.
- `fill_*` outputs are driven from registers and are held stable while `fill_v_o`=1 and `fill_yumi_i`=0.

## Timing
- Reset values: `hdr_ready_and_o`=1 (state e_idle), `beat_ready_and_o`=0, `fill_v_o`=0, `fill_icache_o`=0, `fill_tag_o`=0, `fill_data_o`=0, `err_o`=0; `cnt_r`=0.
- Header accepted in cycle T → first beat can be accepted in cycle T+1.
- Final beat accepted in cycle F → `fill_v_o`=1 in cycle F+1.
- Minimum line latency from header: N+1 cycles (icache 5, dcache 3).
- Back-to-back operation: yumi and the next header in the same cycle cause no bubble. The next fill's first beat can be accepted in the following cycle.
- Backpressure: while in e_out, `beat_ready_and_o`=0 indefinitely.
- Reset asserted mid-collect or mid-out: all state clears immediately and any partial line is discarded. After deassert, the block is in e_idle.
- `fill_yumi_i` asserted while `fill_v_o`=0 is ignored.

## Configuration
- Macro: `BP_PITON_FILL_CWF_EN`.
- Defined: critical-word-first rotation as specified above.
- Undefined: beats are placed in arrival order (s = k). `hdr_word_i` is ignored for placement and the `err_o` check still applies.

## Test plan
- Icache, word 0, beats 0xA,0xB,0xC,0xD with no stalls → `fill_v_o` 5 cycles after the header; `fill_data_o` = {D,C,B,A} (MSB→LSB); tag echoed.
- Icache, word 2, CWF defined, beats A,B,C,D → [63:0]=C, [127:64]=D, [191:128]=A, [255:192]=B. With CWF undefined → {D,C,B,A}.
- Dcache, word 3, beats 0x11,0x22 → `err_o` pulses once. CWF on gives [63:0]=0x22, [127:64]=0x11; upper half = 0; `fill_icache_o`=0.
- Backpressure: hold `fill_yumi_i`=0 for 5 cycles with `beat_v_i`=1 → `beat_ready_and_o`=0 and `fill_data_o` stable throughout. Then yumi plus a new header in the same cycle → the next header is accepted that cycle.
- Reset asserted after 2 of 4 icache beats → outputs return to reset values immediately. A following dcache fill completes correctly with upper half = 0.
